// File: rtl/udp_rx_pkt_fifo.sv
// Store-and-forward buffer for the UDP receive payload stream.
// Whole packets are committed on rlast or dropped; the input is never back-pressured.
module udp_rx_pkt_fifo #(
  parameter int unsigned DATA_DEPTH  = 2048,
  parameter int unsigned PKT_DEPTH   = 16,
  parameter int unsigned MAX_PKT_LEN = 1472
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [7:0]                         udp_rdata_in,
  input  logic                               udp_rvalid_in,
  output logic                               udp_rready_out,
  input  logic                               udp_rlast_in,
  output logic [7:0]                         m_data_out,
  output logic                               m_valid_out,
  input  logic                               m_ready_in,
  output logic                               m_last_out,
  output logic [15:0]                        m_len_out,
  output logic [15:0]                        drop_cnt_out,
  output logic [$clog2(PKT_DEPTH+1)-1:0]     pkt_cnt_out
);

  localparam int unsigned AW  = $clog2(DATA_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned LAW = $clog2(PKT_DEPTH);
  localparam int unsigned LPW = LAW + 1;
  localparam int unsigned CW  = $clog2(PKT_DEPTH + 1);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_STORE = 2'd1;
  localparam logic [1:0] W_DROP  = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_LEN  = 2'd1;
  localparam logic [1:0] R_SEND = 2'd2;

  logic [7:0]  data_ram [DATA_DEPTH];
  logic [15:0] len_fifo [PKT_DEPTH];

  logic           rready_q;
  logic [1:0]     wr_state_q, wr_state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  wr_commit_q, wr_commit_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [LPW-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;

  logic [1:0]     rd_state_q, rd_state_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  fetch_ptr_q, fetch_ptr_d;
  logic [15:0]    fetch_rem_q, fetch_rem_d;
  logic [15:0]    m_len_q, m_len_d;

  logic           r_valid_q, r_last_q;
  logic [7:0]     r_data_q;
  logic           o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [7:0]     o_data_q, o_data_d;
  logic           s_valid_q, s_valid_d, s_last_q, s_last_d;
  logic [7:0]     s_data_q, s_data_d;

  logic           accept, ram_full, too_long, lf_full, lf_empty;
  logic [PW-1:0]  used;
  logic [15:0]    new_len, lf_head;
  logic           ram_we, lf_push, lf_pop, commit, drop;
  logic           pop, last_done, can_issue, issue, issue_last;
  logic [AW-1:0]  issue_addr;
  logic [1:0]     occ;

  assign accept   = udp_rvalid_in & rready_q;
  assign used     = wr_ptr_q - rd_ptr_q;
  assign ram_full = (used == PW'(DATA_DEPTH));
  assign new_len  = (wr_state_q == W_STORE) ? (len_q + 16'd1) : 16'd1;
  assign too_long = (new_len > 16'(MAX_PKT_LEN));
  // Packet slots count the one being sent, so a stalled reader still limits storage.
  assign lf_full  = (pkt_cnt_q == CW'(PKT_DEPTH));
  assign lf_empty = (lf_wr_q == lf_rd_q);
  assign lf_head  = len_fifo[lf_rd_q[LAW-1:0]];

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    len_d       = len_q;
    ram_we      = 1'b0;
    lf_push     = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    if (accept) begin
      if (wr_state_q == W_DROP) begin
        if (udp_rlast_in) begin
          drop       = 1'b1;
          wr_ptr_d   = wr_commit_q;
          wr_state_d = W_IDLE;
        end
      end else if (ram_full || too_long) begin
        if (udp_rlast_in) begin
          drop       = 1'b1;
          wr_ptr_d   = wr_commit_q;
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_DROP;
        end
      end else begin
        ram_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PW'(1);
        len_d      = new_len;
        wr_state_d = W_STORE;
        if (udp_rlast_in) begin
          wr_state_d = W_IDLE;
          if (lf_full) begin
            drop     = 1'b1;
            wr_ptr_d = wr_commit_q;
          end else begin
            lf_push     = 1'b1;
            commit      = 1'b1;
            wr_commit_d = wr_ptr_q + PW'(1);
          end
        end
      end
    end
  end

  assign pop       = o_valid_q & m_ready_in;
  assign last_done = pop & o_last_q;
  assign occ       = 2'(o_valid_q) + 2'(s_valid_q) + 2'(r_valid_q);
  // A new read may only be issued if its data is sure to find a free slot next cycle.
  assign can_issue = ((occ - 2'(pop)) <= 2'd1);

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    fetch_rem_d = fetch_rem_q;
    m_len_d     = m_len_q;
    lf_pop      = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_addr  = fetch_ptr_q[AW-1:0];
    unique case (rd_state_q)
      R_IDLE: if (!lf_empty) rd_state_d = R_LEN;
      R_LEN: begin
        lf_pop      = 1'b1;
        m_len_d     = lf_head;
        issue       = 1'b1;
        issue_addr  = rd_ptr_q[AW-1:0];
        issue_last  = (lf_head == 16'd1);
        fetch_ptr_d = rd_ptr_q + PW'(1);
        fetch_rem_d = lf_head - 16'd1;
        rd_state_d  = R_SEND;
      end
      R_SEND: begin
        if ((fetch_rem_q != 16'd0) && can_issue) begin
          issue       = 1'b1;
          issue_last  = (fetch_rem_q == 16'd1);
          fetch_ptr_d = fetch_ptr_q + PW'(1);
          fetch_rem_d = fetch_rem_q - 16'd1;
        end
        if (last_done) begin
          rd_ptr_d   = fetch_ptr_q;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_last_d  = s_last_q;
    if (pop) begin
      if (s_valid_q) begin
        o_data_d  = s_data_q;
        o_last_d  = s_last_q;
        s_valid_d = 1'b0;
      end else begin
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
      end
    end
    if (r_valid_q) begin
      if (!o_valid_d) begin
        o_valid_d = 1'b1;
        o_data_d  = r_data_q;
        o_last_d  = r_last_q;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = r_data_q;
        s_last_d  = r_last_q;
      end
    end
  end

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + CW'(commit) - CW'(last_done);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    lf_wr_d = lf_wr_q + LPW'(lf_push);
    lf_rd_d = lf_rd_q + LPW'(lf_pop);
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) data_ram[wr_ptr_q[AW-1:0]] <= udp_rdata_in;
    if (issue) r_data_q <= data_ram[issue_addr];
    if (lf_push) len_fifo[lf_wr_q[LAW-1:0]] <= new_len;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rready_q    <= 1'b0;
      wr_state_q  <= W_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      len_q       <= '0;
      drop_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      lf_wr_q     <= '0;
      lf_rd_q     <= '0;
      rd_state_q  <= R_IDLE;
      rd_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      fetch_rem_q <= '0;
      m_len_q     <= '0;
      r_valid_q   <= 1'b0;
      r_last_q    <= 1'b0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_last_q    <= 1'b0;
      s_valid_q   <= 1'b0;
      s_data_q    <= '0;
      s_last_q    <= 1'b0;
    end else begin
      rready_q    <= 1'b1;
      wr_state_q  <= wr_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      len_q       <= len_d;
      drop_cnt_q  <= drop_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      lf_wr_q     <= lf_wr_d;
      lf_rd_q     <= lf_rd_d;
      rd_state_q  <= rd_state_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      fetch_rem_q <= fetch_rem_d;
      m_len_q     <= m_len_d;
      r_valid_q   <= issue;
      r_last_q    <= issue_last;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_last_q    <= o_last_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      s_last_q    <= s_last_d;
    end
  end

  assign udp_rready_out = rready_q;
  assign m_data_out     = o_data_q;
  assign m_valid_out    = o_valid_q;
  assign m_last_out     = o_last_q;
  assign m_len_out      = m_len_q;
  assign drop_cnt_out   = drop_cnt_q;
  assign pkt_cnt_out    = pkt_cnt_q;

endmodule
